puf_eval_sequencer: RTL
=======================

# puf_eval_sequencer

Evaluation sequencer sitting between the PicoBlaze PUF controller and the PUF core. On a start pulse it launches the PUF `NEVAL` times on the currently loaded challenge. For each evaluation it:
- drives the top/bottom trigger signals,
- waits for the PUF ready flag,
- accumulates per-bit ones counts.

It then reports the majority-voted response and the raw counts to the controller's response ports. Repeated evaluation gives the reliability and soft-response figures used in modelling experiments.

## Interface
Parameters:
- `RESP_W`, 3, response bits per evaluation (final XOR bit plus per-APUF bits).
- `NEVAL`, 15, evaluations per start; legal range 1..255.
- `SETTLE`, 8, cycles with triggers low before each launch (challenge/path settle).
- `TRIG_LEN`, 4, cycles both triggers are held high per launch.
- `TIMEOUT`, 1023, max cycles waited for ready before abort; legal range 1..65535.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse when the run ends, normally or by timeout.
- `tig_t` out 1: top-path launch signal to PUF.
- `tig_b` out 1: bottom-path launch signal to PUF.
- `puf_ready` in 1: PUF response-ready flag; level, asynchronous to arbiter settling.
- `puf_resp` in `RESP_W`: PUF response bits, valid while `puf_ready` high.
- `maj_resp` out `RESP_W`: majority response; bit i = 1 iff ones count i > `NEVAL`/2 (integer division).
- `ones_cnt` out 8*`RESP_W`: ones count for bit i in slice [8i+7:8i].
- `timeout_err` out 1: set when a run aborted on timeout; cleared on the next accepted start.

## Operation
- `puf_ready` and `puf_resp` each pass through a 2-flop synchronizer; all decisions use the synchronized copies `rdy_s` and `resp_s`.
- States:
  - IDLE: triggers low. On `start`: clear counters, eval count and `timeout_err`; go to ARM.
  - ARM: triggers low for `SETTLE` cycles; then go to FIRE.
  - FIRE: `tig_t` = `tig_b` = 1 for `TRIG_LEN` cycles; then go to WAIT with triggers low.
  - WAIT: wait-counter increments each cycle.
    - If `rdy_s` = 1: go to ACC.
    - Else if wait count reaches `TIMEOUT`: set `timeout_err`, force `maj_resp` = 0, go to DONE.
  - ACC (one cycle): `ones_cnt`[i] += `resp_s`[i] for every i; eval count += 1; go to RELAX.
  - RELAX: wait for `rdy_s` = 0, bounded by the same `TIMEOUT` rule. Then:
    - if eval count == `NEVAL`: go to DONE;
    - else: go to ARM.
  - DONE (one cycle): `done` = 1. `maj_resp` is updated from counts here, except when aborting on timeout. Then go to IDLE.
- Counters are 8 bits and saturate at 255; saturation is unreachable with legal `NEVAL`.
- `ones_cnt` and `maj_resp` hold their values in IDLE until the next accepted start clears them.
- `start` while not IDLE is ignored, including `start` coincident with `done`.
- `rst_n` low at any time:
  - immediately forces `tig_t`, `tig_b`, `busy`, `done`, `timeout_err`, `maj_resp` and `ones_cnt` to 0, and the synchronizers to 0;
  - FSM returns to IDLE.
  - First accepted start is possible on the first edge after `rst_n` rises.

## Timing
- Reset values of all outputs: 0.
- Start accepted at edge E; `busy` = 1 and ARM from E+1.
- `tig_*` rise at E+1+`SETTLE` and stay high exactly `TRIG_LEN` cycles.
- Ready raw rise at edge R → `rdy_s` high at R+2 → ACC at R+2 → counts visible at R+3.
- Per-evaluation minimum = `SETTLE` + `TRIG_LEN` + 2 (sync) + PUF delay + 1 (ACC) + RELAX duration.
- `done` asserts one cycle after the final RELAX exits. `busy` falls in the same cycle `done` is high. `maj_resp` is valid with `done`.
- Timeout: abort after exactly `TIMEOUT` WAIT cycles with `rdy_s` low.

## Test plan
- PUF model: ready rises 5 cycles after `tig_*` fall and drops 3 cycles later; resp = 3'b101 always; `NEVAL`=15 → `ones_cnt` = {15,0,15}, `maj_resp` = 3'b101, one `done` pulse, `timeout_err` = 0.
- Bit0 returns 1 on evaluations 1..8 and 0 on 9..15 → `ones_cnt`[7:0] = 8, `maj_resp`[0] = 1. With only 7 ones → 7, `maj_resp`[0] = 0.
- PUF never asserts ready, `TIMEOUT`=20 → `done` exactly 20 WAIT cycles after triggers fall; `timeout_err` = 1; `maj_resp` = 0; next start clears `timeout_err`.
- Check trigger waveform: `SETTLE`=8, `TRIG_LEN`=4; start at cycle 0 → `tig_t` = `tig_b` = 1 on cycles 9..12 only; count exactly `NEVAL` trigger pulses per run.
- Extra `start` pulses during a run and coincident with `done` → ignored, single run only.
- Assert `rst_n` low while in FIRE → triggers and all outputs 0 within the same cycle (asynchronous); after release, a fresh run completes correctly.

Source files
------------

// File: rtl/puf_eval_sequencer_if.sv
// Controller/PUF-side signal bundle of the evaluation sequencer.
// master: controller + PUF core side, slave: sequencer side.
interface puf_eval_sequencer_if #(
  parameter int RESP_W = 3
);
  logic                start;
  logic                busy;
  logic                done;
  logic                tig_t;
  logic                tig_b;
  logic                puf_ready;
  logic [RESP_W-1:0]   puf_resp;
  logic [RESP_W-1:0]   maj_resp;
  logic [8*RESP_W-1:0] ones_cnt;
  logic                timeout_err;

  modport master (
    output start, puf_ready, puf_resp,
    input  busy, done, tig_t, tig_b,
    input  maj_resp, ones_cnt, timeout_err
  );

  modport slave (
    input  start, puf_ready, puf_resp,
    output busy, done, tig_t, tig_b,
    output maj_resp, ones_cnt, timeout_err
  );
endinterface

// File: rtl/puf_eval_sequencer.sv
// Repeated PUF evaluation with per-bit ones counting
// and majority vote of the response bits.
module puf_eval_sequencer #(
  parameter int RESP_W   = 3,
  parameter int NEVAL    = 15,
  parameter int SETTLE   = 8,
  parameter int TRIG_LEN = 4,
  parameter int TIMEOUT  = 1023
) (
  input logic                 clk,
  input logic                 rst_n,
  puf_eval_sequencer_if.slave bus
);
  localparam logic [15:0] SET_M = 16'(SETTLE - 1);
  localparam logic [15:0] TRG_M = 16'(TRIG_LEN - 1);
  localparam logic [15:0] TO_M  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  NEV_C = 8'(NEVAL);
  localparam logic [7:0]  HALF  = 8'(NEVAL / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_WAIT,
    S_ACC, S_RELAX, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [7:0]              eval_q, eval_d;
  logic [RESP_W-1:0][7:0]  ones_q, ones_d;
  logic [RESP_W-1:0]       maj_q, maj_d;
  logic [RESP_W-1:0]       maj_w;
  logic                    terr_q, terr_d;
  logic                    rdy_m_q, rdy_s_q;
  logic [RESP_W-1:0]       resp_m_q, resp_s_q;

  // Two-flop synchronizers for the PUF ready flag and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_m_q  <= 1'b0;
      rdy_s_q  <= 1'b0;
      resp_m_q <= '0;
      resp_s_q <= '0;
    end else begin
      rdy_m_q  <= bus.puf_ready;
      rdy_s_q  <= rdy_m_q;
      resp_m_q <= bus.puf_resp;
      resp_s_q <= resp_m_q;
    end
  end

  // Sequencer state, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      eval_q  <= '0;
      ones_q  <= '0;
      maj_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eval_q  <= eval_d;
      ones_q  <= ones_d;
      maj_q   <= maj_d;
      terr_q  <= terr_d;
    end
  end

  // Majority vote of the current ones counts.
  always_comb begin
    maj_w = '0;
    for (int i = 0; i < RESP_W; i++)
      maj_w[i] = (ones_q[i] > HALF);
  end

  // Next state; maj is loaded on entry to DONE so it
  // is valid together with the done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval_d  = eval_q;
    ones_d  = ones_q;
    maj_d   = maj_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ARM;
          cnt_d   = '0;
          eval_d  = '0;
          ones_d  = '0;
          maj_d   = '0;
          terr_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (cnt_q == SET_M) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FIRE: begin
        if (cnt_q == TRG_M) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (rdy_s_q) begin
          state_d = S_ACC;
          cnt_d   = '0;
        end else if (cnt_q == TO_M) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
          maj_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACC: begin
        for (int i = 0; i < RESP_W; i++)
          if (resp_s_q[i] && ones_q[i] != 8'hFF)
            ones_d[i] = ones_q[i] + 8'd1;
        if (eval_q != 8'hFF)
          eval_d = eval_q + 8'd1;
        state_d = S_RELAX;
        cnt_d   = '0;
      end
      S_RELAX: begin
        if (!rdy_s_q) begin
          cnt_d = '0;
          if (eval_q == NEV_C) begin
            state_d = S_DONE;
            maj_d   = maj_w;
          end else begin
            state_d = S_ARM;
          end
        end else if (cnt_q == TO_M) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
          maj_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE) &&
                           (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.tig_t       = (state_q == S_FIRE);
  assign bus.tig_b       = (state_q == S_FIRE);
  assign bus.maj_resp    = maj_q;
  assign bus.ones_cnt    = ones_q;
  assign bus.timeout_err = terr_q;
endmodule
